// File: rtl/wb_writer.sv
// wb_writer: writeback-stage driver producing one registered register-file write per retiring instruction.
// Loads park in WAIT_MEM until mem_rvalid or a freeze-aware timeout; rst is synchronous active-low.
module wb_writer #(
    parameter int SUPPRESS_PC = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wb_en,
    input  logic        in_mem_r_en,
    input  logic [3:0]  in_dest,
    input  logic [31:0] in_alu_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [3:0]  dest_wb,
    output logic [31:0] result_wb,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  ldest_q, ldest_d;
    logic        lwb_q, lwb_d;
    logic        wb_en_q, wb_en_d;
    logic [3:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic        accept;

    assign in_ready  = state_q != WAIT_MEM;
    assign busy      = state_q == WAIT_MEM;
    assign accept    = in_valid & in_ready & ~freeze & ~flush;
    assign wb_en     = wb_en_q;
    assign dest_wb   = dest_q;
    assign result_wb = result_q;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ldest_d  = ldest_q;
        lwb_d    = lwb_q;
        wb_en_d  = 1'b0;
        dest_d   = dest_q;
        result_d = result_q;
        err_d    = err_q;
        if (state_q == WAIT_MEM) begin
            // rvalid is honoured under freeze and beats the timeout on the expiry cycle
            if (mem_rvalid) begin
                state_d = lwb_q ? WRITE : IDLE;
                if (lwb_q) begin
                    wb_en_d  = !((SUPPRESS_PC != 0) && ldest_q == 4'hF);
                    dest_d   = ldest_q;
                    result_d = mem_rdata;
                end
            end else if (!freeze) begin
                if (cnt_q == LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end else begin
            state_d = IDLE;
            if (accept) begin
                if (in_mem_r_en) begin
                    state_d = WAIT_MEM;
                    ldest_d = in_dest;
                    lwb_d   = in_wb_en;
                    cnt_d   = 8'd0;
                end else if (in_wb_en) begin
                    state_d  = WRITE;
                    wb_en_d  = !((SUPPRESS_PC != 0) && in_dest == 4'hF);
                    dest_d   = in_dest;
                    result_d = in_alu_result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            ldest_q  <= 4'd0;
            lwb_q    <= 1'b0;
            wb_en_q  <= 1'b0;
            dest_q   <= 4'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ldest_q  <= ldest_d;
            lwb_q    <= lwb_d;
            wb_en_q  <= wb_en_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: vector table plus hand sequences; expected writes queue up and are matched on each wb_en pulse.
module tb_wb_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0, flush = 1'b0, in_valid = 1'b0, in_wb_en = 1'b0, in_mem_r_en = 1'b0;
    logic [3:0]  in_dest = 4'd0;
    logic [31:0] in_alu_result = 32'd0, mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic        in_ready, wb_en, busy, err;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {logic [3:0] d; logic [31:0] r;} wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        flush;
        logic        freeze;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic        exp_write;
    } vec_t;
    vec_t vecs[8];

    wb_writer #(.SUPPRESS_PC(1), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .dest_wb(dest_wb), .result_wb(result_wb), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // every write pulse must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (wb_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got dest=%0d data=%h, none expected", dest_wb, result_wb);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (dest_wb !== e.d || result_wb !== e.r) begin
                    n_bad++;
                    $display("FAIL write_data: got dest=%0d data=%h want dest=%0d data=%h",
                             dest_wb, result_wb, e.d, e.r);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] r);
        wr_t e;
        e.d = d;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic [3:0] d, input logic [31:0] a);
        in_valid      = v;
        in_wb_en      = wb;
        in_mem_r_en   = mr;
        in_dest       = d;
        in_alu_result = a;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd3,  32'h0000_00AA, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'd6,  32'h0000_0066, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd6,  32'h0000_0067, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd15, 32'h0000_0F0F, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 4'd0,  32'h1234_5678, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 4'd7,  32'h0000_0077, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'd8,  32'h0000_0088, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 4'd14, 32'hFFFF_FFFF, 1'b1};

        cycle();
        cycle();
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_dest", {28'd0, dest_wb}, 32'd0);
        chk("rst_result", result_wb, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {30'd0, in_ready, busy}, 32'd2);
        rst = 1'b1;
        cycle();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_write) expect_wr(vecs[i].dest, vecs[i].alu);
            flush  = vecs[i].flush;
            freeze = vecs[i].freeze;
            drive(1'b1, vecs[i].wb, 1'b0, vecs[i].dest, vecs[i].alu);
            cycle();
            drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            flush  = 1'b0;
            freeze = 1'b0;
            if (vecs[i].dest == 4'd15 && vecs[i].exp_write == 1'b0)
                chk("pc_dest_updates", {28'd0, dest_wb}, 32'd15);
            cycle();
            cycle();
            chk($sformatf("vec%0d_drain", i), exp_q.size(), 32'd0);
        end

        // back-to-back ALU writes
        expect_wr(4'd1, 32'h11);
        expect_wr(4'd2, 32'h22);
        expect_wr(4'd4, 32'h44);
        drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h11);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h22);
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h44);
        chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle();
        cycle();
        chk("b2b_drain", exp_q.size(), 32'd0);

        // load with 4-cycle latency, data arriving while frozen
        drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h0000_0100);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ld_wait%0d", i), {30'd0, in_ready, busy}, 32'd1);
            flush = 1'b1;
            cycle();
            flush = 1'b0;
        end
        expect_wr(4'd5, 32'hDEAD_BEEF);
        freeze     = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        cycle();
        freeze     = 1'b0;
        mem_rvalid = 1'b0;
        chk("ld_wb_en", {31'd0, wb_en}, 32'd1);
        chk("ld_ready_back", {30'd0, in_ready, busy}, 32'd2);
        cycle();
        chk("ld_drain", exp_q.size(), 32'd0);

        // timeout: two frozen cycles hold the counter, then 8 counted cycles expire
        drive(1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_0200);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            freeze = (i < 2);
            cycle();
            chk($sformatf("to_busy%0d", i), {30'd0, busy, err}, 32'd2);
        end
        freeze = 1'b0;
        cycle();
        chk("to_err", {29'd0, err, busy, in_ready}, 32'd5);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0BAD;
        cycle();
        mem_rvalid = 1'b0;
        chk("late_rvalid", {31'd0, wb_en}, 32'd0);
        cycle();
        cycle();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // freeze holds acceptance until it drops
        freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd8, 32'h88);
        cycle();
        cycle();
        cycle();
        chk("frz_no_write", {31'd0, wb_en}, 32'd0);
        expect_wr(4'd8, 32'h88);
        freeze = 1'b0;
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        chk("frz_write", {31'd0, wb_en}, 32'd1);
        cycle();
        chk("frz_drain", exp_q.size(), 32'd0);

        // reset in the middle of a load
        drive(1'b1, 1'b1, 1'b1, 4'd10, 32'h0000_0300);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle();
        chk("rm_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        cycle();
        chk("rm_outs", {dest_wb, wb_en, err, busy, in_ready}, 32'd1);
        chk("rm_result", result_wb, 32'd0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        cycle();
        mem_rvalid = 1'b0;
        chk("rm_ignore", {31'd0, wb_en}, 32'd0);
        cycle();
        cycle();
        chk("final_drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
